// File: rtl/mib_arb_pkg.sv
// Shared types for the cmd-bus arbiter:
// FSM states, capture slot layout and defaults.
package mib_arb_pkg;

  localparam int MIB_N_REQ     = 4;
  localparam int MIB_ADDR_BITS = 24;
  localparam int MIB_DATA_BITS = 32;
  localparam int MIB_WDOG_CLKS = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } t_arb_state;

  typedef struct packed {
    logic                     rd_wr_n;
    logic [MIB_ADDR_BITS-1:0] addr;
    logic [MIB_DATA_BITS-1:0] wdata;
  } t_req_slot;

endpackage

// File: rtl/mib_cmd_arbiter_rr_pick.sv
// Round-robin selector: first set request
// at or after the pointer, wrapping at N-1.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] gnt_o,
  output logic          vld_o
);

  logic [IW:0] idx;

  // Scan from the far end so the nearest request wins.
  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = {1'b0, ptr_i} + (IW+1)'(i);
      if (idx >= (IW+1)'(N)) begin
        idx = idx - (IW+1)'(N);
      end
      if (req_i[idx[IW-1:0]]) begin
        gnt_o = idx[IW-1:0];
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mib_cmd_arbiter.sv
// Shares one mib_master cmd port between
// N_REQ requesters, one transaction at a time.
module mib_cmd_arbiter
  import mib_arb_pkg::*;
#(
  parameter int N_REQ       = MIB_N_REQ,
  parameter int ADDR_BITS   = MIB_ADDR_BITS,
  parameter int DATA_BITS   = MIB_DATA_BITS,
  parameter int P_WDOG_CLKS = MIB_WDOG_CLKS
) (
  input  logic                       i_sysclk,
  input  logic                       i_arst,
  input  logic [N_REQ-1:0]           i_req_sel,
  input  logic [N_REQ-1:0]           i_req_rd_wr_n,
  input  logic [N_REQ*ADDR_BITS-1:0] i_req_byte_addr,
  input  logic [N_REQ*DATA_BITS-1:0] i_req_wdata,
  output logic [N_REQ-1:0]           o_req_ack,
  output logic [N_REQ-1:0]           o_req_timeout,
  output logic [DATA_BITS-1:0]       o_req_rdata,
  output logic [N_REQ-1:0]           o_req_busy,
  output logic [N_REQ-1:0]           o_req_overrun,
  input  logic                       i_overrun_clr,
  output logic                       o_cmd_sel,
  output logic                       o_cmd_rd_wr_n,
  output logic [ADDR_BITS-1:0]       o_cmd_byte_addr,
  output logic [DATA_BITS-1:0]       o_cmd_wdata,
  input  logic                       i_cmd_ack,
  input  logic [DATA_BITS-1:0]       i_cmd_rdata,
  input  logic                       i_cmd_mib_timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(P_WDOG_CLKS);
  localparam logic [IW-1:0] LAST_IDX =
    IW'(N_REQ - 1);
  localparam logic [WW-1:0] WDOG_LAST =
    WW'(P_WDOG_CLKS - 1);

  t_req_slot slot_q [N_REQ];

  logic [N_REQ-1:0] pend_q, pend_d;
  logic [N_REQ-1:0] ovr_q, ovr_d;
  logic [N_REQ-1:0] acc_vec, cmp_vec;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] tmo_q, tmo_d;

  t_arb_state state_q, state_d;

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] pick_gnt;
  logic          pick_vld;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          done;

  logic                 cmd_sel_q, cmd_sel_d;
  logic                 cmd_rd_q, cmd_rd_d;
  logic [ADDR_BITS-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_BITS-1:0] cmd_wd_q, cmd_wd_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;

  // A completing requester may re-request on
  // the same edge; the new request wins.
  assign acc_vec = i_req_sel &
                   (~pend_q | cmp_vec);
  assign pend_d  = acc_vec |
                   (pend_q & ~cmp_vec);
  assign ovr_d   = (i_req_sel & ~acc_vec) |
                   (ovr_q &
                    {N_REQ{~i_overrun_clr}});

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req_i (pend_q),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .vld_o (pick_vld)
  );

  // Latch request fields into the slot on accept.
  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      for (int r = 0; r < N_REQ; r++) begin
        slot_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < N_REQ; r++) begin
        if (acc_vec[r]) begin
          slot_q[r].rd_wr_n <= i_req_rd_wr_n[r];
          slot_q[r].addr    <=
            i_req_byte_addr[r*ADDR_BITS +: ADDR_BITS];
          slot_q[r].wdata   <=
            i_req_wdata[r*DATA_BITS +: DATA_BITS];
        end
      end
    end
  end

  // Pending and sticky overrun flags.
  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      pend_q <= '0;
      ovr_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  // Next-state, grant, watchdog and responses.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    wdog_d     = wdog_q;
    cmd_sel_d  = 1'b0;
    cmd_rd_d   = cmd_rd_q;
    cmd_addr_d = cmd_addr_q;
    cmd_wd_d   = cmd_wd_q;
    rdata_d    = rdata_q;
    ack_d      = '0;
    tmo_d      = '0;
    done       = 1'b0;
    cmp_vec    = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = ISSUE;
          gnt_d      = pick_gnt;
          cmd_sel_d  = 1'b1;
          cmd_rd_d   = slot_q[pick_gnt].rd_wr_n;
          cmd_addr_d = slot_q[pick_gnt].addr;
          cmd_wd_d   = slot_q[pick_gnt].wdata;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wdog_d  = '0;
      end
      WAIT: begin
        wdog_d = wdog_q + WW'(1);
        if (i_cmd_ack) begin
          done         = 1'b1;
          ack_d[gnt_q] = 1'b1;
          if (cmd_rd_q) begin
            rdata_d = i_cmd_rdata;
          end
        end else if (i_cmd_mib_timeout ||
                     wdog_q == WDOG_LAST) begin
          done         = 1'b1;
          tmo_d[gnt_q] = 1'b1;
        end
        if (done) begin
          state_d = IDLE;
          ptr_d   = (gnt_q == LAST_IDX) ?
                    '0 : gnt_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (done) begin
      cmp_vec[gnt_q] = 1'b1;
    end
  end

  // FSM, pointer and watchdog registers.
  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
    end
  end

  // Downstream command and upstream response regs.
  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      cmd_sel_q  <= 1'b0;
      cmd_rd_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_wd_q   <= '0;
      rdata_q    <= '0;
      ack_q      <= '0;
      tmo_q      <= '0;
    end else begin
      cmd_sel_q  <= cmd_sel_d;
      cmd_rd_q   <= cmd_rd_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_wd_q   <= cmd_wd_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      tmo_q      <= tmo_d;
    end
  end

  assign o_req_ack       = ack_q;
  assign o_req_timeout   = tmo_q;
  assign o_req_rdata     = rdata_q;
  assign o_req_busy      = pend_q;
  assign o_req_overrun   = ovr_q;
  assign o_cmd_sel       = cmd_sel_q;
  assign o_cmd_rd_wr_n   = cmd_rd_q;
  assign o_cmd_byte_addr = cmd_addr_q;
  assign o_cmd_wdata     = cmd_wd_q;

endmodule

// File: tb/tb_mib_cmd_arbiter.sv
// Directed bench for mib_cmd_arbiter with
// hand-computed expectations.
module tb_mib_cmd_arbiter;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            arst = 1'b0;
  logic [N-1:0]    sel = '0;
  logic [N-1:0]    rdwr = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wd = '0;
  logic            ovr_clr = 1'b0;
  logic            cack = 1'b0;
  logic            ctmo = 1'b0;
  logic [DW-1:0]   crdata = '0;

  logic [N-1:0]  ack, tmo, busy, ovr;
  logic [DW-1:0] rdata;
  logic          csel, crd;
  logic [AW-1:0] caddr;
  logic [DW-1:0] cwd;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mib_cmd_arbiter #(
    .N_REQ       (N),
    .ADDR_BITS   (AW),
    .DATA_BITS   (DW),
    .P_WDOG_CLKS (64)
  ) dut (
    .i_sysclk          (clk),
    .i_arst            (arst),
    .i_req_sel         (sel),
    .i_req_rd_wr_n     (rdwr),
    .i_req_byte_addr   (addr),
    .i_req_wdata       (wd),
    .o_req_ack         (ack),
    .o_req_timeout     (tmo),
    .o_req_rdata       (rdata),
    .o_req_busy        (busy),
    .o_req_overrun     (ovr),
    .i_overrun_clr     (ovr_clr),
    .o_cmd_sel         (csel),
    .o_cmd_rd_wr_n     (crd),
    .o_cmd_byte_addr   (caddr),
    .o_cmd_wdata       (cwd),
    .i_cmd_ack         (cack),
    .i_cmd_rdata       (crdata),
    .i_cmd_mib_timeout (ctmo)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int r,
                      input logic rd,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    sel[r]             = 1'b1;
    rdwr[r]            = rd;
    addr[r*AW +: AW]   = a;
    wd[r*DW +: DW]     = d;
  endtask

  function automatic logic any_out();
    return |{ack, tmo, rdata, busy, ovr,
             csel, crd, caddr, cwd};
  endfunction

  task automatic issue(input string tag,
                       input logic rd,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] d,
                       output int lat);
    lat = 0;
    while (!csel && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, " sel"}, 64'(csel), 1);
    chk({tag, " fields"},
        64'({crd, caddr, cwd}),
        64'({rd, a, d}));
    tick();
    chk({tag, " sel drop"}, 64'(csel), 0);
  endtask

  // kind: 0 ack, 1 mib timeout, 3 both
  task automatic respond(input int kind,
                         input int dly,
                         input logic [DW-1:0] rd);
    repeat (dly) tick();
    crdata = rd;
    cack   = (kind == 0 || kind == 3);
    ctmo   = (kind == 1 || kind == 3);
    tick();
    cack   = 1'b0;
    ctmo   = 1'b0;
    crdata = '0;
  endtask

  task automatic resp(input string tag,
                      input logic [N-1:0] ea,
                      input logic [N-1:0] et);
    chk(tag, 64'({ack, tmo}), 64'({ea, et}));
  endtask

  initial begin
    #200000;
    $display("FAIL global: time limit hit");
    $fatal(1, "time limit");
  end

  initial begin
    int lat;
    int n;
    #1 arst = 1'b1;
    #1;
    chk("reset outs", 64'(any_out()), 0);
    tick();
    tick();
    arst = 1'b0;
    tick();

    // 1: single write
    post(1, 1'b0, 24'h200004, 32'h01010202);
    tick();
    sel = '0;
    chk("t1 busy", 64'(busy), 64'h2);
    issue("t1", 1'b0, 24'h200004,
          32'h01010202, lat);
    chk("t1 latency", 64'(lat), 1);
    respond(0, 10, 32'hBAD0BAD0);
    resp("t1 ack", 4'b0010, 4'b0000);
    chk("t1 busy fall", 64'(busy), 0);
    tick();
    resp("t1 ack once", 4'b0000, 4'b0000);

    // 2: read, then rdata held over a write
    post(0, 1'b1, 24'h200000, 32'h0);
    tick();
    sel = '0;
    issue("t2 rd", 1'b1, 24'h200000, 32'h0, lat);
    respond(0, 3, 32'hDEADBEEF);
    resp("t2 ack", 4'b0001, 4'b0000);
    chk("t2 rdata", 64'(rdata), 64'hDEADBEEF);
    post(3, 1'b0, 24'h300000, 32'h33);
    tick();
    sel = '0;
    issue("t2 wr", 1'b0, 24'h300000, 32'h33, lat);
    respond(0, 2, 32'h55555555);
    resp("t2 wr ack", 4'b1000, 4'b0000);
    chk("t2 rdata hold", 64'(rdata),
        64'hDEADBEEF);

    // 3: contention, pointer now 0
    for (int r = 0; r < N; r++) begin
      post(r, 1'b0, 24'(24'h100000 + r * 4),
           32'(32'hC0 + r));
    end
    tick();
    sel = '0;
    chk("t3 busy all", 64'(busy), 64'hF);
    for (int r = 0; r < N; r++) begin
      issue("t3 order", 1'b0,
            24'(24'h100000 + r * 4),
            32'(32'hC0 + r), lat);
      respond(0, 1, 32'h0);
      resp("t3 ack", 4'(1 << r), 4'b0000);
    end
    post(3, 1'b0, 24'h130000, 32'h3);
    post(0, 1'b0, 24'h100000, 32'h0);
    tick();
    sel = '0;
    issue("t3 wrap0", 1'b0, 24'h100000,
          32'h0, lat);
    respond(0, 1, 32'h0);
    resp("t3 wrap0 ack", 4'b0001, 4'b0000);
    issue("t3 wrap3", 1'b0, 24'h130000,
          32'h3, lat);
    respond(0, 1, 32'h0);
    resp("t3 wrap3 ack", 4'b1000, 4'b0000);

    // 4: downstream timeout, then watchdog
    post(1, 1'b0, 24'h410000, 32'h41);
    post(2, 1'b0, 24'h420000, 32'h42);
    tick();
    sel = '0;
    issue("t4 r1", 1'b0, 24'h410000, 32'h41, lat);
    respond(1, 4, 32'h0);
    resp("t4 mib tmo", 4'b0000, 4'b0010);
    issue("t4 r2", 1'b0, 24'h420000, 32'h42, lat);
    n = 0;
    while (tmo == '0 && n < 100) begin
      tick();
      n++;
    end
    chk("t4 wdog clks", 64'(n), 64);
    resp("t4 wdog", 4'b0000, 4'b0100);
    chk("t4 rdata kept", 64'(rdata),
        64'hDEADBEEF);
    post(0, 1'b1, 24'h430000, 32'h0);
    tick();
    sel = '0;
    issue("t4 both", 1'b1, 24'h430000,
          32'h0, lat);
    respond(3, 2, 32'h0A0B0C0D);
    resp("t4 ack wins", 4'b0001, 4'b0000);
    chk("t4 rdata", 64'(rdata), 64'h0A0B0C0D);
    tick();
    cack = 1'b1;
    ctmo = 1'b1;
    tick();
    cack = 1'b0;
    ctmo = 1'b0;
    tick();
    resp("t4 stray", 4'b0000, 4'b0000);

    // 5: overrun and sel at completion edge
    post(2, 1'b0, 24'h520000, 32'h52);
    tick();
    post(2, 1'b0, 24'h5200FF, 32'hFF);
    tick();
    sel = '0;
    chk("t5 ovr set", 64'(ovr), 64'h4);
    issue("t5 first", 1'b0, 24'h520000,
          32'h52, lat);
    respond(0, 2, 32'h0);
    resp("t5 ack", 4'b0100, 4'b0000);
    n = 0;
    repeat (6) begin
      tick();
      if (csel) n++;
    end
    chk("t5 one op", 64'(n), 0);
    chk("t5 ovr sticky", 64'(ovr), 64'h4);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("t5 ovr clr", 64'(ovr), 0);
    post(2, 1'b0, 24'h530000, 32'h53);
    tick();
    post(2, 1'b0, 24'h53FFFF, 32'hEE);
    ovr_clr = 1'b1;
    tick();
    sel = '0;
    ovr_clr = 1'b0;
    chk("t5 set wins", 64'(ovr), 64'h4);
    issue("t5 second", 1'b0, 24'h530000,
          32'h53, lat);
    respond(0, 1, 32'h0);
    resp("t5 ack2", 4'b0100, 4'b0000);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    post(3, 1'b1, 24'h600000, 32'h0);
    tick();
    sel = '0;
    issue("t5 rd3", 1'b1, 24'h600000, 32'h0, lat);
    repeat (2) tick();
    cack   = 1'b1;
    crdata = 32'h11111111;
    post(3, 1'b0, 24'h610000, 32'h61);
    tick();
    cack   = 1'b0;
    crdata = '0;
    sel    = '0;
    resp("t5 edge ack", 4'b1000, 4'b0000);
    chk("t5 edge busy", 64'(busy), 64'h8);
    chk("t5 edge no ovr", 64'(ovr), 0);
    chk("t5 edge rdata", 64'(rdata),
        64'h11111111);
    issue("t5 renew", 1'b0, 24'h610000,
          32'h61, lat);
    chk("t5 renew lat", 64'(lat), 1);
    respond(0, 1, 32'h0);
    resp("t5 renew ack", 4'b1000, 4'b0000);
    chk("t5 renew busy", 64'(busy), 0);

    // 6: async reset mid-WAIT
    post(1, 1'b1, 24'h700000, 32'h0);
    tick();
    sel = '0;
    issue("t6 rd", 1'b1, 24'h700000, 32'h0, lat);
    repeat (3) tick();
    #2;
    arst = 1'b1;
    cack = 1'b1;
    #1;
    chk("t6 async outs", 64'(any_out()), 0);
    tick();
    tick();
    cack = 1'b0;
    arst = 1'b0;
    n = 0;
    repeat (5) begin
      tick();
      if (ack != '0 || tmo != '0) n++;
    end
    chk("t6 no pulse", 64'(n), 0);
    chk("t6 busy", 64'(busy), 0);
    post(0, 1'b1, 24'h710000, 32'h0);
    tick();
    sel = '0;
    issue("t6 fresh", 1'b1, 24'h710000,
          32'h0, lat);
    chk("t6 fresh lat", 64'(lat), 1);
    respond(0, 5, 32'hCAFEF00D);
    resp("t6 fresh ack", 4'b0001, 4'b0000);
    chk("t6 rdata", 64'(rdata), 64'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
